// File: rtl/diff_code_pkg.sv
// Shared field layout, FSM state type and check-sum helper for the diff code
// receive filter and the matching transmit-side encoder.
package diff_code_pkg;

    localparam int ADDR_W      = 4;
    localparam int PAYLOAD_W   = 16;
    localparam int CHECK_W     = 6;
    localparam int CODE_W      = 26;

    localparam int CHECK_LSB   = 0;
    localparam int PAYLOAD_LSB = CHECK_LSB + CHECK_W;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_W;

    localparam logic [ADDR_W-1:0] BROADCAST_ADDR = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } filt_state_e;

    // Sum of address and both payload bytes, kept modulo 64.
    function automatic logic [CHECK_W-1:0] calc_check(
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [7:0] sum;
        sum = 8'(addr) + payload[15:8] + payload[7:0];
        return sum[CHECK_W-1:0];
    endfunction

endpackage

// File: rtl/diff_code_filter_if.sv
// Valid/ready output channel carrying decoded address and payload of an
// emitted code.
interface diff_code_filter_if import diff_code_pkg::*; ();

    logic [ADDR_W-1:0]    addr_out;
    logic [PAYLOAD_W-1:0] payload_out;
    logic                 valid_out;
    logic                 ready_in;

    modport master (output addr_out, output payload_out, output valid_out, input ready_in);
    modport slave  (input addr_out, input payload_out, input valid_out, output ready_in);

endinterface

// File: rtl/diff_code_check.sv
// Combinational split of a captured code into fields, with check-sum and
// address acceptance flags.
module diff_code_check
    import diff_code_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MY_ADDR = 4'h3
) (
    input  logic [CODE_W-1:0]    code_i,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 chk_ok_o,
    output logic                 addr_ok_o
);

    logic [CHECK_W-1:0] check;

    always_comb begin
        addr_o    = code_i[ADDR_LSB +: ADDR_W];
        payload_o = code_i[PAYLOAD_LSB +: PAYLOAD_W];
        check     = code_i[CHECK_LSB +: CHECK_W];
        chk_ok_o  = (check == calc_check(addr_o, payload_o));
        addr_ok_o = (addr_o == MY_ADDR) || (addr_o == BROADCAST_ADDR);
    end

endmodule

// File: rtl/diff_code_filter.sv
// Repeat/noise filter for received codes; emits after REPEATS identical valid
// codes. Define DIFF_FILTER_STATS_EN to build the error/drop counters.
//
// state | meaning
// IDLE  | no burst in progress
// COUNT | collecting identical valid codes, not yet emitted
// HOLD  | burst emitted, identical repeats swallowed until gap timeout
module diff_code_filter
    import diff_code_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MY_ADDR    = 4'h3,
    parameter int                REPEATS    = 2,
    parameter int                GAP_CYCLES = 2_000_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               new_code_in,
    diff_code_filter_if.master out_if,
    output logic [7:0]         err_count_out,
    output logic [7:0]         drop_count_out
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [3:0]       REP_N    = 4'(REPEATS);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [CODE_W-1:0]    cap_q, cap_d;
    logic                 cap_vld_q, cap_vld_d;
    filt_state_e          state_q, state_d, cur_state;
    logic [CODE_W-1:0]    last_q, last_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q, valid_d;
    logic                 timeout, code_good, emit;
    logic [ADDR_W-1:0]    chk_addr;
    logic [PAYLOAD_W-1:0] chk_payload;
    logic                 chk_ok, addr_ok;

    diff_code_check #(.MY_ADDR(MY_ADDR)) u_check (
        .code_i    (cap_q),
        .addr_o    (chk_addr),
        .payload_o (chk_payload),
        .chk_ok_o  (chk_ok),
        .addr_ok_o (addr_ok)
    );

    always_comb begin
        cap_vld_d = new_code_in;
        cap_d     = new_code_in ? code_in : cap_q;
    end

    always_comb begin
        timeout   = (state_q != IDLE) && (gap_q == GAP_LAST);
        cur_state = timeout ? IDLE : state_q;
        code_good = cap_vld_q && chk_ok && addr_ok;
        state_d   = cur_state;
        cnt_d     = timeout ? 4'd0 : cnt_q;
        last_d    = last_q;
        gap_d     = (cur_state == IDLE) ? '0 : gap_q + GAP_ONE;
        emit      = 1'b0;
        if (cap_vld_q) begin
            gap_d = '0;
            if (!code_good) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else if (cur_state != IDLE && cap_q == last_q) begin
                if (cur_state == COUNT) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == REP_N) begin
                        emit    = 1'b1;
                        state_d = HOLD;
                    end
                end
            end else begin
                // First code of a new burst, from any state.
                last_d = cap_q;
                cnt_d  = 4'd1;
                if (REP_N == 4'd1) begin
                    emit    = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = COUNT;
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        if (emit) begin
            if (!valid_q || out_if.ready_in) begin
                valid_d   = 1'b1;
                addr_d    = chk_addr;
                payload_d = chk_payload;
            end
        end else if (valid_q && out_if.ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            state_q   <= IDLE;
            last_q    <= '0;
            cnt_q     <= 4'd0;
            gap_q     <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
        end
    end

    assign out_if.addr_out    = addr_q;
    assign out_if.payload_out = payload_q;
    assign out_if.valid_out   = valid_q;

`ifdef DIFF_FILTER_STATS_EN
    logic [7:0] err_q, err_d, drop_q, drop_d;
    logic       chk_fail, drop_hit;

    always_comb begin
        chk_fail = cap_vld_q && !chk_ok;
        drop_hit = emit && valid_q && !out_if.ready_in;
        err_d    = err_q;
        drop_d   = drop_q;
        if (chk_fail && err_q != 8'hFF)  err_d  = err_q + 8'd1;
        if (drop_hit && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 8'h00;
            drop_q <= 8'h00;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_count_out  = err_q;
    assign drop_count_out = drop_q;
`else
    assign err_count_out  = 8'h00;
    assign drop_count_out = 8'h00;
`endif

endmodule

// File: doc/diff_code_filter.md
Name: diff_code_filter

Overview:
- Consumes the 26-bit codes and `new_code` strobes produced by the diff_rx receiver.
- Validates each code's checksum and address field, then suppresses noise and auto-repeat.
- A code is emitted only after REPEATS consecutive identical valid codes, each arriving within GAP_CYCLES of the previous one.
- Emitted codes go to the application logic over a valid/ready interface as decoded address/payload.

Parameters:
- MY_ADDR, 4'h3, address accepted in addition to broadcast 4'hF.
- REPEATS, 2, consecutive identical valid codes required before emit (range 1..15).
- GAP_CYCLES, 2_000_000, max cycles between successive codes of one burst; also the hold-release timeout.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- code_in  input  26  code from receiver, sampled only when new_code_in=1.
- new_code_in  input  1  single-cycle strobe marking a fresh code.
- addr_out  output  4  address of the emitted code.
- payload_out  output  16  payload of the emitted code.
- valid_out  output  1  output holds an unconsumed code.
- ready_in  input  1  consumer accepts when valid_out&&ready_in.
- err_count_out  output  8  saturating count of checksum failures (see Optional Feature).
- drop_count_out  output  8  saturating count of emits lost to backpressure (see Optional Feature).

Behaviour:
- Code format:
  - [25:22] addr, [21:6] payload, [5:0] check.
  - Valid iff check == (addr + payload[15:8] + payload[7:0]) mod 64, with zero-extended unsigned adds truncated to 6 bits.
  - Valid iff addr==MY_ADDR or addr==4'hF.
- Reset (asynchronous assert, synchronous release):
  - valid_out=0; addr_out, payload_out, counters all 0.
  - FSM=IDLE; repeat count=0; gap timer=0; last-code register=0.
- Sampling:
  - A strobe in cycle N latches code_in into the capture register at edge N.
  - Check and compare happen in cycle N+1.
  - If an emit occurs, valid_out rises at edge N+2. Fixed latency of 2 cycles.
- Gap timer:
  - Counts up every cycle while FSM!=IDLE and clears on every accepted strobe.
  - Reaching GAP_CYCLES-1 forces FSM to IDLE and repeat count to 0.
- FSM states:
  - IDLE:
    - Valid code → last=code, count=1, go to COUNT.
    - If REPEATS==1, emit immediately and go to HOLD instead.
    - Invalid code → stay IDLE; a checksum failure increments err_count.
  - COUNT:
    - Valid code equal to last → count+1. When count reaches REPEATS, emit and go to HOLD.
    - Valid code different from last → last=code, count=1, stay in COUNT.
    - Invalid code → count=0, go to IDLE.
    - Timeout → IDLE.
  - HOLD:
    - Identical valid codes are swallowed and restart the gap timer (held button, no re-emit).
    - Different valid code → treated as IDLE's first code (count=1, COUNT).
    - Invalid code or timeout → IDLE.
- Output register / handshake:
  - Emit when valid_out=0 or ready_in=1 in the same cycle: load addr/payload and set valid_out=1.
  - Emit when valid_out=1 and ready_in=0: code dropped, drop_count+1, output unchanged, FSM still goes to HOLD.
  - valid_out=1 and ready_in=1 with no emit → valid_out=0 next edge.
  - Data is stable while valid_out=1 and ready_in=0.
- Strobe handling:
  - A strobe arriving while the previous code is in its check cycle is accepted normally, since strobes are at least one bit period apart.
  - Back-to-back strobes are still processed in order (one-entry capture pipeline, no loss).
- Counters saturate at 8'hFF.
- Reset mid-burst discards all state; a pending output is lost.

Optional Feature:
- DIFF_FILTER_STATS_EN.
- Defined: err_count_out and drop_count_out are live saturating counters.
- Undefined: counter registers are not synthesized and both ports are tied to 8'h00.
- All other behaviour is identical either way.

Decomposition:
- Package diff_code_pkg holds:
  - field width/offset localparams (ADDR_W=4, PAYLOAD_W=16, CHECK_W=6, CODE_W=26);
  - BROADCAST_ADDR=4'hF;
  - state enum {IDLE, COUNT, HOLD};
  - a function computing the 6-bit check.
- The same package is reused by a future tx-side encoder.
- One natural sub-module: diff_code_check (combinational field split, check compare, address match).

Test Plan:
- Basic emit:
  - Stimulus: two strobes of 26'h0E95682 (addr 3, payload A55A, check 02), 3000 cycles apart, ready_in=1, GAP_CYCLES=5000.
  - Response: exactly one valid_out pulse, 2 cycles after the second strobe, with addr_out=3 and payload_out=16'hA55A.
- Checksum failure:
  - Stimulus: 26'h0E95683 twice.
  - Response: no emit; err_count_out=2 with DIFF_FILTER_STATS_EN, 0 without.
- Timeout:
  - Stimulus: two valid identical codes 6000 cycles apart (GAP_CYCLES=5000).
  - Response: no emit.
  - Follow-on: a third identical code 100 cycles later → one emit.
- Hold suppression:
  - Stimulus: six identical valid codes 1000 cycles apart.
  - Response: exactly one emit. After 5000 idle cycles, two more codes produce a second emit.
- Address filtering and backpressure:
  - Stimulus: addr 4'h5 codes → ignored. Addr 4'hF codes → emitted.
  - Stimulus: ready_in=0 while a second distinct code qualifies.
  - Response: first code held stable, drop_count_out=1.
- Reset mid-burst:
  - Stimulus: rst_in low for 1 cycle between the first and second strobe.
  - Response: all outputs 0; the second strobe alone does not emit.
